// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative signed multiplier / divider.
// One operation at a time: WIDTH shift-add iterations for multiply and WIDTH
// restoring-division iterations for divide, both on operand magnitudes. The
// sign is applied on the final iteration. A divide by zero finishes
// immediately and leaves hi/lo untouched.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             div_or_mult,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_div_q, op_div_d;
  logic [WIDTH-1:0] work_hi_q, work_hi_d;
  logic [WIDTH-1:0] work_lo_q, work_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  // Iteration datapath temporaries
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   work_lo_cur;
  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     rem_sh;
  logic               qbit;
  logic [WIDTH-1:0]   it_hi;
  logic [WIDTH-1:0]   it_lo;
  logic [2*WIDTH-1:0] prod;
  logic               res_neg;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return '0 - x;
  endfunction

  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? neg_w(x) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return '0 - x;
  endfunction

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

  // Next-state, datapath iteration and registered-output computation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    op_div_d   = op_div_q;
    work_hi_d  = work_hi_q;
    work_lo_d  = work_lo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    // The low work word is seeded with |a| on the first iteration, so the
    // accept edge only has to latch the raw operands.
    mag_b       = abs_w(b_q);
    work_lo_cur = (cnt_q == '0) ? abs_w(a_q) : work_lo_q;
    res_neg     = a_q[WIDTH-1] ^ b_q[WIDTH-1];

    // Multiply step: conditionally add |b| into the upper word, shift right.
    msum = {1'b0, work_hi_q} + (work_lo_cur[0] ? {1'b0, mag_b} : '0);

    // Divide step: shift next dividend bit into the partial remainder and
    // subtract |b| when it fits.
    rem_sh = {work_hi_q, work_lo_cur[WIDTH-1]};
    qbit   = (rem_sh >= {1'b0, mag_b});

    if (op_div_q) begin
      it_hi = qbit ? (rem_sh[WIDTH-1:0] - mag_b) : rem_sh[WIDTH-1:0];
      it_lo = {work_lo_cur[WIDTH-2:0], qbit};
    end else begin
      it_hi = msum[WIDTH:1];
      it_lo = {msum[0], work_lo_cur[WIDTH-1:1]};
    end
    prod = {it_hi, it_lo};

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d        = op_a;
          b_d        = op_b;
          op_div_d   = div_or_mult;
          cnt_d      = '0;
          work_hi_d  = '0;
          work_lo_d  = '0;
          busy_d     = 1'b1;
          div_zero_d = 1'b0;
          if (div_or_mult && (op_b == '0)) begin
            div_zero_d = 1'b1;
            done_d     = 1'b1;
            state_d    = DONE;
          end else begin
            state_d = div_or_mult ? DIV : MULT;
          end
        end
      end
      MULT, DIV: begin
        work_hi_d = it_hi;
        work_lo_d = it_lo;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          if (op_div_q) begin
            lo_d = res_neg ? neg_w(it_lo) : it_lo;
            hi_d = a_q[WIDTH-1] ? neg_w(it_hi) : it_hi;
          end else begin
            {hi_d, lo_d} = res_neg ? neg_2w(prod) : prod;
          end
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_div_q   <= 1'b0;
      work_hi_q  <= '0;
      work_lo_q  <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_div_q   <= op_div_d;
      work_hi_q  <= work_hi_d;
      work_lo_q  <= work_lo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and randomized checks of muldiv_seq against a
// transaction-level model built on 64-bit integer arithmetic.
module tb_muldiv_seq;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          div_or_mult = 1'b0;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic          busy, done, div_zero;
  logic [W-1:0]  hi, lo;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  muldiv_seq #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .div_or_mult (div_or_mult),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .done        (done),
    .div_zero    (div_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: signed 64-bit product, truncating division.
  function automatic void ref_op(input logic d, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] rh, output logic [W-1:0] rl);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!d) begin
      p  = sa * sb;
      rh = p[63:32];
      rl = p[31:0];
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      rh = r[31:0];
      rl = q[31:0];
    end
  endfunction

  // Transaction-level model: an operation occupies WIDTH+1 edges (or one
  // for a zero divisor), then one DONE cycle, then returns to idle.
  logic         m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int           m_rem = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
      m_hi = '0; m_lo = '0; m_rem = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1;
        if (div_or_mult && op_b == '0) begin
          m_dz = 1'b1; m_done = 1'b1; m_rem = 0;
        end else begin
          m_dz = 1'b0;
          ref_op(div_or_mult, op_a, op_b, p_hi, p_lo);
          m_rem = W;
        end
      end
    end else if (m_done) begin
      m_done = 1'b0; m_busy = 1'b0;
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clock) begin
    chk("cyc busy", 64'(busy), 64'(m_busy));
    chk("cyc done", 64'(done), 64'(m_done));
    chk("cyc div_zero", 64'(div_zero), 64'(m_dz));
    chk("cyc hi", 64'(hi), 64'(m_hi));
    chk("cyc lo", 64'(lo), 64'(m_lo));
  end

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (done !== 1'b1 && n < 100);
  endtask

  task automatic do_op(input logic d, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W-1:0] eh, el;
    logic         edz;
    int           lat, n;
    if (d && b == '0) begin
      eh = last_hi; el = last_lo; edz = 1'b1; lat = 1;
    end else begin
      ref_op(d, a, b, eh, el); edz = 1'b0; lat = W + 1;
    end
    @(negedge clock);
    start = 1'b1; div_or_mult = d; op_a = a; op_b = b;
    @(negedge clock);
    start = 1'b0; op_a = $urandom; op_b = $urandom; div_or_mult = 1'($urandom);
    chk({tag, " busy after accept"}, 64'(busy), 64'(1));
    if (!edz) chk({tag, " div_zero cleared"}, 64'(div_zero), 64'(0));
    n = 1;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " hi"}, 64'(hi), 64'(eh));
    chk({tag, " lo"}, 64'(lo), 64'(el));
    chk({tag, " div_zero"}, 64'(div_zero), 64'(edz));
    last_hi = eh;
    last_lo = el;
  endtask

  logic [W-1:0] corner [8] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000,
                               32'h7FFFFFFF, 32'h2, 32'hFFFFFFFE, 32'h0};

  initial begin
    int n;
    logic d;
    logic [W-1:0] a, b;

    #1 reset = 1'b1;
    #2;
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset div_zero", 64'(div_zero), 64'(0));
    chk("reset hi", 64'(hi), 64'(0));
    chk("reset lo", 64'(lo), 64'(0));
    repeat (2) @(negedge clock);
    reset = 1'b0;

    do_op(1'b0, 32'h00000007, 32'hFFFFFFFD, "mul 7*-3");
    chk("mul 7*-3 hi lit", 64'(hi), 64'h00000000FFFFFFFF);
    chk("mul 7*-3 lo lit", 64'(lo), 64'h00000000FFFFFFEB);
    do_op(1'b0, 32'h80000000, 32'h80000000, "mul min*min");
    chk("mul min*min hi lit", 64'(hi), 64'h0000000040000000);
    chk("mul min*min lo lit", 64'(lo), 64'h0);
    do_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, "mul -1*-1");
    chk("mul -1*-1 hi lit", 64'(hi), 64'h0);
    chk("mul -1*-1 lo lit", 64'(lo), 64'h1);
    do_op(1'b1, 32'hFFFFFFF9, 32'h00000002, "div -7/2");
    chk("div -7/2 lo lit", 64'(lo), 64'h00000000FFFFFFFD);
    chk("div -7/2 hi lit", 64'(hi), 64'h00000000FFFFFFFF);
    do_op(1'b1, 32'h00000007, 32'hFFFFFFFE, "div 7/-2");
    chk("div 7/-2 lo lit", 64'(lo), 64'h00000000FFFFFFFD);
    chk("div 7/-2 hi lit", 64'(hi), 64'h1);
    do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, "div ovf");
    chk("div ovf lo lit", 64'(lo), 64'h0000000080000000);
    chk("div ovf hi lit", 64'(hi), 64'h0);
    chk("div ovf dz lit", 64'(div_zero), 64'h0);
    do_op(1'b1, 32'h00002211, 32'h00000100, "div prep");
    do_op(1'b1, 32'h00000005, 32'h00000000, "div 5/0");
    chk("div 5/0 hi lit", 64'(hi), 64'h11);
    chk("div 5/0 lo lit", 64'(lo), 64'h22);
    chk("div 5/0 dz lit", 64'(div_zero), 64'h1);
    do_op(1'b0, 32'h00000003, 32'h00000004, "mul after dz");
    chk("mul after dz lo lit", 64'(lo), 64'hC);

    // Second start while busy must be ignored
    @(negedge clock);
    start = 1'b1; div_or_mult = 1'b0; op_a = 32'h1234; op_b = 32'h5678;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    start = 1'b1; div_or_mult = 1'b1; op_a = 32'h9; op_b = 32'h9;
    @(negedge clock);
    start = 1'b0;
    wait_done(n);
    chk("ignore start latency", 64'(n + 5), 64'(W + 1));
    chk("ignore start hi", 64'(hi), 64'h0);
    chk("ignore start lo", 64'(lo), 64'h06260060);

    // start held high: back-to-back acceptance on the first idle edge
    @(negedge clock);
    start = 1'b1; div_or_mult = 1'b0; op_a = 32'd5; op_b = 32'd6;
    wait_done(n);
    chk("held start first latency", 64'(n), 64'(W + 1));
    wait_done(n);
    start = 1'b0;
    chk("held start gap", 64'(n), 64'(W + 2));
    chk("held start lo", 64'(lo), 64'd30);
    last_hi = '0; last_lo = 32'd30;

    // Asynchronous reset during a divide
    @(negedge clock);
    start = 1'b1; div_or_mult = 1'b1; op_a = 32'hFFFFFF9C; op_b = 32'd7;
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("async rst busy", 64'(busy), 64'(0));
    chk("async rst done", 64'(done), 64'(0));
    chk("async rst div_zero", 64'(div_zero), 64'(0));
    chk("async rst hi", 64'(hi), 64'(0));
    chk("async rst lo", 64'(lo), 64'(0));
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    reset = 1'b0;
    last_hi = '0; last_lo = '0;
    repeat (40) begin
      @(negedge clock);
      chk("no done after abort", 64'(done), 64'(0));
    end
    do_op(1'b1, 32'hFFFFFF9C, 32'd7, "div after reset");

    // Randomized operations mixing corner and random operands
    for (int i = 0; i < 30; i++) begin
      d = 1'($urandom);
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 7)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 7)] : $urandom;
      do_op(d, a, b, d ? "rand div" : "rand mul");
    end

    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
